// File: rtl/melody_sequencer.sv
// Pinball music sequencer: game state + score pulse -> note frequency for the tone PWM.
// Optional score jingle is compiled in by defining MELODY_SEQ_SFX_EN.
module melody_sequencer #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BEAT_HZ     = 4,
    parameter int SILENT_FREQ = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  state,
    input  logic        sfx_trig,
    output logic [31:0] tone_freq,
    output logic        beat_tick,
    output logic        seq_done,
    output logic        sfx_busy
);
    localparam int BEAT_CYCLES = CLK_HZ / BEAT_HZ;
    localparam int JING_CYCLES = BEAT_CYCLES >> 2;
    localparam int CW          = $clog2(BEAT_CYCLES);
    localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_CYCLES - 1);
    localparam logic [CW-1:0] JING_LAST = CW'(JING_CYCLES - 1);
    localparam logic [2:0]  ST_WAIT = 3'd1;
    localparam logic [2:0]  ST_OVER = 3'd4;
    localparam logic [31:0] SIL     = 32'(SILENT_FREQ);

    if (BEAT_CYCLES < 4) begin : g_beat_check
        $error("BEAT_CYCLES must be at least 4");
    end

    function automatic logic [31:0] bg_note(input logic [2:0] st, input logic [3:0] i);
        logic [31:0] f;
        f = SIL;
        if (st == ST_WAIT) begin
            case (i)
                4'd0, 4'd4, 4'd10:        f = 32'd524;
                4'd1, 4'd3, 4'd5, 4'd9,
                4'd11:                    f = 32'd660;
                4'd2, 4'd6, 4'd8, 4'd12:  f = 32'd784;
                4'd7:                     f = 32'd1048;
                default:                  f = SIL;
            endcase
        end else if (st == ST_OVER) begin
            case (i)
                4'd0:    f = 32'd392;
                4'd1:    f = 32'd349;
                4'd2:    f = 32'd330;
                4'd3:    f = 32'd294;
                4'd4:    f = 32'd262;
                default: f = SIL;
            endcase
        end
        return f;
    endfunction

    logic [2:0]    state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          beat_tick_q, beat_tick_d;
    logic          seq_done_q, seq_done_d;
    logic [31:0]   tone_freq_q, tone_freq_d;
    logic          restart;

`ifdef MELODY_SEQ_SFX_EN
    logic          sfx_busy_q, sfx_busy_d;
    logic [1:0]    jidx_q, jidx_d;
    logic [CW-1:0] jcnt_q, jcnt_d;

    function automatic logic [31:0] jingle_note(input logic [1:0] i);
        logic [31:0] f;
        case (i)
            2'd0:    f = 32'd1048;
            2'd1:    f = 32'd1320;
            2'd2:    f = 32'd1568;
            default: f = 32'd2096;
        endcase
        return f;
    endfunction
`else
    logic unused_sfx_trig;
    assign unused_sfx_trig = sfx_trig;
`endif

    always_comb begin
        state_d     = state;
        restart     = (state != state_q);
        beat_cnt_d  = beat_cnt_q + 1'b1;
        idx_d       = idx_q;
        beat_tick_d = 1'b0;
        seq_done_d  = seq_done_q;
        if (restart) begin
            beat_cnt_d = '0;
            idx_d      = 4'd0;
            seq_done_d = 1'b0;
        end else if (beat_cnt_q == BEAT_LAST) begin
            beat_cnt_d  = '0;
            beat_tick_d = 1'b1;
            // OVER is one-shot: park on the final rest and flag completion
            if (state_q == ST_OVER) begin
                if (idx_q >= 4'd6) begin
                    idx_d      = 4'd7;
                    seq_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end else begin
                idx_d = idx_q + 4'd1;
            end
        end

`ifdef MELODY_SEQ_SFX_EN
        sfx_busy_d = sfx_busy_q;
        jidx_d     = jidx_q;
        jcnt_d     = jcnt_q;
        if (sfx_trig) begin
            sfx_busy_d = 1'b1;
            jidx_d     = 2'd0;
            jcnt_d     = '0;
        end else if (sfx_busy_q) begin
            if (jcnt_q == JING_LAST) begin
                jcnt_d = '0;
                if (jidx_q == 2'd3) sfx_busy_d = 1'b0;
                else                jidx_d     = jidx_q + 2'd1;
            end else begin
                jcnt_d = jcnt_q + 1'b1;
            end
        end
        tone_freq_d = sfx_busy_q ? jingle_note(jidx_q) : bg_note(state_q, idx_q);
`else
        tone_freq_d = bg_note(state_q, idx_q);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_WAIT;
            idx_q       <= 4'd0;
            beat_cnt_q  <= '0;
            beat_tick_q <= 1'b0;
            seq_done_q  <= 1'b0;
            tone_freq_q <= SIL;
`ifdef MELODY_SEQ_SFX_EN
            sfx_busy_q  <= 1'b0;
            jidx_q      <= 2'd0;
            jcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            beat_cnt_q  <= beat_cnt_d;
            beat_tick_q <= beat_tick_d;
            seq_done_q  <= seq_done_d;
            tone_freq_q <= tone_freq_d;
`ifdef MELODY_SEQ_SFX_EN
            sfx_busy_q  <= sfx_busy_d;
            jidx_q      <= jidx_d;
            jcnt_q      <= jcnt_d;
`endif
        end
    end

    assign tone_freq = tone_freq_q;
    assign beat_tick = beat_tick_q;
    assign seq_done  = seq_done_q;
`ifdef MELODY_SEQ_SFX_EN
    assign sfx_busy  = sfx_busy_q;
`else
    assign sfx_busy  = 1'b0;
`endif
endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer at CLK_HZ=32, BEAT_HZ=4 (8-cycle beats, 2-cycle jingle notes).
module tb_melody_sequencer;
`ifdef MELODY_SEQ_SFX_EN
    localparam bit SFX = 1'b1;
`else
    localparam bit SFX = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  state;
    logic        sfx_trig;
    logic [31:0] tone_freq;
    logic        beat_tick, seq_done, sfx_busy;

    int checks = 0;
    int passed = 0;

    melody_sequencer #(.CLK_HZ(32), .BEAT_HZ(4), .SILENT_FREQ(20000)) dut (
        .clk(clk), .reset(reset), .state(state), .sfx_trig(sfx_trig),
        .tone_freq(tone_freq), .beat_tick(beat_tick), .seq_done(seq_done), .sfx_busy(sfx_busy)
    );

    always #5 clk = ~clk;

    int wait_mel[16] = '{524, 660, 784, 660, 524, 660, 784, 1048,
                         784, 660, 524, 660, 784, 20000, 20000, 20000};
    int over_mel[8]  = '{392, 349, 330, 294, 262, 20000, 20000, 20000};

    // Jingle window, one row per edge j after the return to WAIT (index j-1)
    int tone_sfx[30] = '{524, 524, 1048, 1048, 1320, 1320, 1568, 1568, 2096, 2096,
                         660, 660, 660, 1048, 1048, 1320, 1320, 1568, 1568, 2096,
                         2096, 1048, 1048, 1320, 1320, 1568, 1568, 2096, 2096, 660};
    int tone_plain[30] = '{524, 524, 524, 524, 524, 524, 524, 524, 660, 660,
                           660, 660, 660, 660, 660, 660, 784, 784, 784, 784,
                           784, 784, 784, 784, 660, 660, 660, 660, 660, 660};
    bit busy_sfx[30] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0,
                         0, 0, 1, 1, 1, 1, 1, 1, 1, 1,
                         1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    bit trig_v[30]   = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0,
                         0, 0, 1, 0, 0, 0, 0, 0, 0, 0,
                         1, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    typedef struct {
        logic trig;
        int   tone;
        logic busy;
        logic tick;
    } vec_t;
    vec_t jv[30];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        for (int j = 0; j < 30; j++) begin
            jv[j].trig = trig_v[j];
            jv[j].tone = SFX ? tone_sfx[j] : tone_plain[j];
            jv[j].busy = SFX ? busy_sfx[j] : 1'b0;
            jv[j].tick = ((j + 1) % 8 == 0);
        end

        reset = 1'b1; state = 3'd1; sfx_trig = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_tone", tone_freq, 20000);
            check("rst_tick", beat_tick, 0);
            check("rst_done", seq_done, 0);
            check("rst_busy", sfx_busy, 0);
        end
        reset = 1'b0;

        // WAIT loop: 140 edges, wraps through all 16 notes
        for (int n = 1; n <= 140; n++) begin
            step();
            check($sformatf("wait_tone[%0d]", n), tone_freq, wait_mel[((n - 1) / 8) % 16]);
            check($sformatf("wait_tick[%0d]", n), beat_tick, (n % 8 == 0));
            check($sformatf("wait_done[%0d]", n), seq_done, 0);
        end

        // OVER one-shot, switched mid-note
        state = 3'd4;
        step();
        check("over_restart_tone", tone_freq, 660);
        check("over_restart_tick", beat_tick, 0);
        for (int m = 1; m <= 110; m++) begin
            step();
            check($sformatf("over_tone[%0d]", m), tone_freq, over_mel[((m - 1) / 8 > 7) ? 7 : (m - 1) / 8]);
            check($sformatf("over_done[%0d]", m), seq_done, (m >= 56));
            check($sformatf("over_tick[%0d]", m), beat_tick, (m % 8 == 0));
        end

        state = 3'd1;
        step();
        check("back_done", seq_done, 0);
        check("back_tone", tone_freq, 20000);

        // Jingle table, including a retrigger on the last jingle note
        for (int j = 0; j < 30; j++) begin
            sfx_trig = jv[j].trig;
            step();
            check($sformatf("jing_tone[%0d]", j + 1), tone_freq, jv[j].tone);
            check($sformatf("jing_busy[%0d]", j + 1), sfx_busy, jv[j].busy);
            check($sformatf("jing_tick[%0d]", j + 1), beat_tick, jv[j].tick);
        end
        sfx_trig = 1'b0;

        // Async reset while OVER is done and the jingle is sounding
        state = 3'd4;
        step();
        w = 0;
        while (seq_done !== 1'b1 && w < 100) begin
            step();
            w++;
        end
        check("over2_done_reached", seq_done, 1);
        sfx_trig = 1'b1;
        step();
        sfx_trig = 1'b0;
        step();
        check("pre_rst_busy", sfx_busy, SFX);
        check("pre_rst_done", seq_done, 1);
        #3;
        reset = 1'b1;
        #1;
        check("arst_tone", tone_freq, 20000);
        check("arst_tick", beat_tick, 0);
        check("arst_done", seq_done, 0);
        check("arst_busy", sfx_busy, 0);
        state = 3'd1;
        step();
        step();
        reset = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            step();
            check($sformatf("post_tone[%0d]", n), tone_freq, wait_mel[(n - 1) / 8]);
            check($sformatf("post_tick[%0d]", n), beat_tick, (n % 8 == 0));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
